// File: rtl/rr_enc16_pkg.sv
// Shared types and sizing for the rr_enc16 round-robin arbiter/encoder.
// N request lines encoded onto a W-bit index.
package rr_enc16_pkg;

  localparam int N = 16;
  localparam int W = 4;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_e;

  function automatic logic [N-1:0] onehot(
    input logic [W-1:0] idx
  );
    logic [N-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_enc16_if.sv
// Request/grant bundle between requesters and the rr_enc16 arbiter.
// The arbiter side uses the slave modport.
interface rr_enc16_if;
  import rr_enc16_pkg::*;

  logic         en;
  logic [N-1:0] req;
  logic         ack;
  logic [W-1:0] sel;
  logic [N-1:0] grant;
  logic         valid;

  modport master (
    output en,
    output req,
    output ack,
    input  sel,
    input  grant,
    input  valid
  );

  modport slave (
    input  en,
    input  req,
    input  ack,
    output sel,
    output grant,
    output valid
  );

endinterface

// File: rtl/rr_enc16_penc16.sv
// Circular priority encoder: first set bit of req starting at start.
// Rotates right by start, finds lowest set bit, adds start back mod N.
module penc16
  import rr_enc16_pkg::*;
(
  input  logic [N-1:0] req,
  input  logic [W-1:0] start,
  output logic [W-1:0] idx,
  output logic         hit
);

  logic [N-1:0] rot;
  logic [W-1:0] off;
  logic [W:0]   lsh;

  // Left shift of N for start=0 yields zero, keeping the rotate exact.
  assign lsh = (W+1)'(N) - {1'b0, start};
  assign rot = (req >> start) | (req << lsh);

  always_comb begin
    off = '0;
    for (int i = N-1; i >= 0; i--) begin
      if (rot[i]) off = i[W-1:0];
    end
  end

  assign idx = off + start;
  assign hit = |req;

endmodule

// File: rtl/rr_enc16.sv
// Round-robin arbiter: registers a W-bit grant index and holds it
// until ack; search pointer advances past each completed grant.
module rr_enc16
  import rr_enc16_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  rr_enc16_if.slave   bus
);

  state_e       state_q, state_d;
  logic [W-1:0] sel_q,   sel_d;
  logic [W-1:0] ptr_q,   ptr_d;
  logic [W-1:0] pe_idx;
  logic         pe_hit;
  logic         valid;

  penc16 u_penc (
    .req   (bus.req),
    .start (ptr_q),
    .idx   (pe_idx),
    .hit   (pe_hit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      sel_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.en && pe_hit) begin
          state_d = S_GRANT;
          sel_d   = pe_idx;
        end
      end
      S_GRANT: begin
        // Abort wins over ack and leaves the pointer alone.
        if (!bus.en) begin
          state_d = S_IDLE;
        end else if (bus.ack) begin
          state_d = S_IDLE;
          ptr_d   = sel_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign valid     = (state_q == S_GRANT);
  assign bus.valid = valid;
  assign bus.sel   = sel_q;
  assign bus.grant = valid ? onehot(sel_q) : '0;

endmodule

// File: tb/tb_rr_enc16.sv
// Directed self-checking bench for rr_enc16.
// Inputs change 1ns after each rising edge; outputs checked there too.
module tb_rr_enc16;
  import rr_enc16_pkg::*;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;

  rr_enc16_if bus ();

  rr_enc16 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_grant(
    input string       tag,
    input logic [W-1:0] s
  );
    logic [N-1:0] g;
    g = '0;
    g[s] = 1'b1;
    chk({tag, ".valid"}, 32'(bus.valid), 32'd1);
    chk({tag, ".sel"},   32'(bus.sel),   32'(s));
    chk({tag, ".grant"}, 32'(bus.grant), 32'(g));
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".valid"}, 32'(bus.valid), 32'd0);
    chk({tag, ".grant"}, 32'(bus.grant), 32'd0);
  endtask

  task automatic do_ack();
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;
  endtask

  initial begin
    n_chk   = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    bus.en  = 1'b0;
    bus.req = '0;
    bus.ack = 1'b0;
    tick();
    tick();
    chk_idle("rst");
    chk("rst.sel", 32'(bus.sel), 32'd0);

    // 1: reset mid-grant
    rst_n   = 1'b1;
    bus.en  = 1'b1;
    bus.req = 16'h0020;
    tick();
    chk_grant("g5", 4'd5);
    rst_n = 1'b0;
    #1;
    chk_idle("async_rst");
    chk("async_rst.sel", 32'(bus.sel), 32'd0);
    bus.req = 16'h0001;
    #1;
    rst_n = 1'b1;
    tick();
    chk_grant("post_rst", 4'd0);
    do_ack();
    chk_idle("post_rst_ack");

    // 2: full rotation from ptr=0
    rst_n = 1'b0;
    #1;
    rst_n   = 1'b1;
    bus.req = 16'hFFFF;
    for (int i = 0; i <= N; i++) begin
      tick();
      chk_grant($sformatf("rot%0d", i), 4'(i % N));
      do_ack();
      chk_idle($sformatf("rot_gap%0d", i));
    end

    // 3: wrap search, ptr=1 now
    bus.req = 16'h2000;
    tick();
    chk_grant("g13", 4'd13);
    do_ack();
    bus.req = 16'h0009;
    tick();
    chk_grant("wrap0", 4'd0);
    do_ack();
    tick();
    chk_grant("wrap3", 4'd3);
    do_ack();

    // 4: hold while req changes, ptr=4
    bus.req = 16'h0080;
    tick();
    chk_grant("hold7a", 4'd7);
    bus.req = 16'h0100;
    tick();
    chk_grant("hold7b", 4'd7);
    tick();
    chk_grant("hold7c", 4'd7);
    do_ack();
    chk_idle("hold_ack");
    tick();
    chk_grant("after_hold8", 4'd8);
    do_ack();

    // 5: abort, ptr=9
    bus.req = 16'h0010;
    tick();
    chk_grant("abort4", 4'd4);
    bus.en = 1'b0;
    tick();
    chk_idle("aborted");
    tick();
    chk_idle("en_low");
    bus.en = 1'b1;
    tick();
    chk_grant("regrant4", 4'd4);
    do_ack();

    // 6: ack noise in idle, ptr=5
    bus.req = '0;
    bus.ack = 1'b1;
    tick();
    chk_idle("noise1");
    tick();
    chk_idle("noise2");
    chk("noise.sel", 32'(bus.sel), 32'd4);
    bus.ack = 1'b0;
    bus.req = 16'hFFFF;
    tick();
    chk_grant("ptr_kept5", 4'd5);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
